ann_load_sequencer: RTL and testbench

Controller that sequences one ANN classification run. It fetches every coefficient set (image plus weight banks) from the verification bus through a get-data/busy handshake, then pulses start to the ANN core. It waits for done, latches the seven-segment result and reports completion or timeout. It sits between the top-level control inputs, the verification bus and the ANN core, replacing the direct wiring of request/busy/loaded signals.

---
 rtl/ann_ctrl_pkg.sv | 19 +
 rtl/ann_timeout_counter.sv | 33 +++
 rtl/ann_load_sequencer.sv | 169 ++++++++++++++++
 tb/tb_ann_load_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ann_ctrl_pkg.sv
// Shared types and constants for the ANN load sequencer.
//   ann_seq_state_t        : controller FSM state encoding
//   SEG_BLANK              : seven-segment pattern for "nothing latched yet"
//   DEFAULT_TIMEOUT_CYCLES : default bound on any single wait state
package ann_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XFER,
        START,
        RUN,
        ERR
    } ann_seq_state_t;

    localparam logic [7:0] SEG_BLANK              = 8'hFF;
    localparam int         DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/ann_timeout_counter.sv
// Wait-state watchdog for the ANN load sequencer.
//   clk, rst : clock, async active-high reset
//   clear    : restart the count from zero (takes priority over enable)
//   enable   : count this cycle (controller is in a timed wait state)
//   expired  : enabled and the count has reached TIMEOUT_CYCLES-1
module ann_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Saturates at LAST so a stalled controller can never wrap back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != LAST)
            count <= count + 1'b1;
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/ann_load_sequencer.sv
// Sequences one ANN classification run: fetches NUM_SETS coefficient sets
// over the verification bus (get_data/bus_busy handshake), pulses
// start_detecting to the ANN core, waits for ann_done and latches the result.
//   start, abort          : run request (IDLE only) / cancel from any state
//   get_data, which_data  : bus request and index of the set being fetched
//   bus_busy              : bus transfer in progress (rise = ack, fall = end)
//   image_weights_loaded  : every set of the current run has been transferred
//   start_detecting       : one-cycle kick to the ANN core
//   ann_done, ann_seven_seg : core completion and its result
//   seven_seg             : last successfully latched result (blank after reset)
//   done, busy, error     : success pulse, not-idle flag, sticky timeout flag
module ann_load_sequencer
    import ann_ctrl_pkg::*;
#(
    parameter int NUM_SETS       = 4,
    parameter int SEL_W          = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             get_data,
    output logic [SEL_W-1:0] which_data,
    input  logic             bus_busy,
    output logic             image_weights_loaded,
    output logic             start_detecting,
    input  logic             ann_done,
    input  logic [7:0]       ann_seven_seg,
    output logic [7:0]       seven_seg,
    output logic             done,
    output logic             busy,
    output logic             error
);

    localparam logic [SEL_W-1:0] LAST_SET = SEL_W'(NUM_SETS - 1);

    ann_seq_state_t   state, state_next;
    logic [SEL_W-1:0] set_idx_next;
    logic             get_data_next;
    logic             loaded_next;
    logic             start_det_next;
    logic [7:0]       seg_next;
    logic             done_next;
    logic             error_next;
    logic             timer_clear;
    logic             timer_en;
    logic             timer_expired;

    // which_data is the set index register itself, so it is stable for the
    // whole REQ/XFER pair of a set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            which_data           <= '0;
            get_data             <= 1'b0;
            image_weights_loaded <= 1'b0;
            start_detecting      <= 1'b0;
            seven_seg            <= SEG_BLANK;
            done                 <= 1'b0;
            busy                 <= 1'b0;
            error                <= 1'b0;
        end else begin
            state                <= state_next;
            which_data           <= set_idx_next;
            get_data             <= get_data_next;
            image_weights_loaded <= loaded_next;
            start_detecting      <= start_det_next;
            seven_seg            <= seg_next;
            done                 <= done_next;
            busy                 <= (state_next != IDLE);
            error                <= error_next;
        end
    end

    always_comb begin
        state_next     = state;
        set_idx_next   = which_data;
        get_data_next  = get_data;
        loaded_next    = image_weights_loaded;
        start_det_next = 1'b0;
        seg_next       = seven_seg;
        done_next      = 1'b0;
        error_next     = error;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next    = REQ;
                    error_next    = 1'b0;
                    set_idx_next  = '0;
                    loaded_next   = 1'b0;
                    get_data_next = 1'b1;
                end
            end
            REQ: begin
                // bus_busy already high on the first REQ cycle is a valid ack.
                if (bus_busy) begin
                    state_next    = XFER;
                    get_data_next = 1'b0;
                end else if (timer_expired) begin
                    state_next = ERR;
                end
            end
            XFER: begin
                if (!bus_busy) begin
                    if (which_data == LAST_SET) begin
                        state_next     = START;
                        loaded_next    = 1'b1;
                        start_det_next = 1'b1;
                    end else begin
                        state_next    = REQ;
                        set_idx_next  = which_data + 1'b1;
                        get_data_next = 1'b1;
                    end
                end else if (timer_expired) begin
                    state_next = ERR;
                end
            end
            START: state_next = RUN;
            RUN: begin
                // A result arriving on the expiry cycle still counts.
                if (ann_done) begin
                    state_next  = IDLE;
                    seg_next    = ann_seven_seg;
                    done_next   = 1'b1;
                    loaded_next = 1'b0;
                end else if (timer_expired) begin
                    state_next = ERR;
                end
            end
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (state_next == ERR) begin
            error_next    = 1'b1;
            get_data_next = 1'b0;
            loaded_next   = 1'b0;
        end

        // abort overrides every other event; result and error stay as they were.
        if (abort && state != IDLE) begin
            state_next     = IDLE;
            get_data_next  = 1'b0;
            loaded_next    = 1'b0;
            start_det_next = 1'b0;
            done_next      = 1'b0;
            seg_next       = seven_seg;
            error_next     = error;
        end
    end

    // Any state change restarts the watchdog, so each timed state gets a
    // fresh budget on entry.
    assign timer_clear = (state_next != state);
    assign timer_en    = (state == REQ) || (state == XFER) || (state == RUN);

    ann_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .expired(timer_expired)
    );

endmodule

// File: tb/tb_ann_load_sequencer.sv
// Self-checking bench for ann_load_sequencer: directed scenarios with
// randomized bus timing and results, checked against a small behavioural
// model (expected set-index order, fetch counts, last latched result).
module tb_ann_load_sequencer;

    localparam int NUM_SETS = 4;
    localparam int SEL_W    = 2;
    localparam int TMO      = 1024;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             bus_busy = 1'b0;
    logic             ann_done = 1'b0;
    logic [7:0]       ann_seven_seg = 8'h00;
    logic             get_data;
    logic [SEL_W-1:0] which_data;
    logic             image_weights_loaded;
    logic             start_detecting;
    logic [7:0]       seven_seg;
    logic             done;
    logic             busy;
    logic             error;

    int n_cmp = 0;
    int n_bad = 0;

    // Model / monitor state
    int         gd_rises    = 0;
    int         done_pulses = 0;
    logic       gd_q        = 1'b0;
    int         wd_log[$];
    logic [7:0] model_seg   = 8'hFF;

    always #5 clk = ~clk;

    ann_load_sequencer #(
        .NUM_SETS(NUM_SETS),
        .SEL_W(SEL_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .get_data(get_data),
        .which_data(which_data),
        .bus_busy(bus_busy),
        .image_weights_loaded(image_weights_loaded),
        .start_detecting(start_detecting),
        .ann_done(ann_done),
        .ann_seven_seg(ann_seven_seg),
        .seven_seg(seven_seg),
        .done(done),
        .busy(busy),
        .error(error)
    );

    // Records every new bus request and the index it asked for.
    always @(posedge clk) begin
        #2;
        if (get_data === 1'b1 && gd_q !== 1'b1) begin
            gd_rises++;
            wd_log.push_back(int'(which_data));
        end
        gd_q = get_data;
        if (done === 1'b1) done_pulses++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_gd_high(input int k);
        int t = 0;
        while (get_data !== 1'b1 && t < 50) begin
            step(1);
            t++;
        end
        check($sformatf("get_data_set%0d", k), 32'(get_data), 1);
    endtask

    // One set: wait for the request, ack after `ack` cycles, stay busy `xl` cycles.
    task automatic fetch_set(input int k, input int ack, input int xl);
        wait_gd_high(k);
        check($sformatf("which_data_set%0d", k), 32'(which_data), k);
        step(ack);
        check("req_held", 32'(get_data), 1);
        check("which_stable", 32'(which_data), k);
        bus_busy = 1'b1;
        step(1);
        check("ack_drops_get_data", 32'(get_data), 0);
        step(xl - 1);
        bus_busy = 1'b0;
        step(1);
    endtask

    task automatic run_full(input logic [7:0] seg, input bit fixed, input bit start_in_run);
        int rises0 = gd_rises;
        int dones0 = done_pulses;
        wd_log.delete();
        do_start();
        for (int k = 0; k < NUM_SETS; k++) begin
            if (fixed) fetch_set(k, 2, 5);
            else       fetch_set(k, int'($urandom_range(0, 4)), int'($urandom_range(1, 6)));
        end
        check("loaded_after_last", 32'(image_weights_loaded), 1);
        check("start_det_pulse", 32'(start_detecting), 1);
        step(1);
        check("start_det_drop", 32'(start_detecting), 0);
        check("loaded_in_run", 32'(image_weights_loaded), 1);
        if (start_in_run) begin
            start = 1'b1;
            step(1);
            start = 1'b0;
        end
        step(int'($urandom_range(0, 5)));
        ann_done      = 1'b1;
        ann_seven_seg = seg;
        step(1);
        ann_done      = 1'b0;
        ann_seven_seg = 8'($urandom);
        model_seg     = seg;
        check("seven_seg_latched", 32'(seven_seg), 32'(model_seg));
        check("done_pulse", 32'(done), 1);
        check("busy_after_done", 32'(busy), 0);
        check("loaded_cleared", 32'(image_weights_loaded), 0);
        step(1);
        check("done_one_cycle", 32'(done), 0);
        step(3);
        check("no_extra_req", 32'(get_data), 0);
        check("req_count", 32'(gd_rises - rises0), NUM_SETS);
        check("done_count", 32'(done_pulses - dones0), 1);
        check("wd_seq_len", 32'(wd_log.size()), NUM_SETS);
        for (int i = 0; i < wd_log.size(); i++)
            check("wd_seq", 32'(wd_log[i]), i);
    endtask

    initial begin
        int cnt;
        int rises0;
        int dones0;

        // ---- reset state
        #1 rst = 1'b1;
        step(2);
        check("rst_get_data", 32'(get_data), 0);
        check("rst_which_data", 32'(which_data), 0);
        check("rst_loaded", 32'(image_weights_loaded), 0);
        check("rst_start_det", 32'(start_detecting), 0);
        check("rst_seven_seg", 32'(seven_seg), 32'h0FF);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_error", 32'(error), 0);
        rst = 1'b0;
        step(2);

        // ---- nominal run, then randomized runs (one with start during RUN)
        run_full(8'h92, 1'b1, 1'b0);
        run_full(8'($urandom), 1'b0, 1'b0);
        run_full(8'($urandom), 1'b0, 1'b1);
        run_full(8'($urandom), 1'b0, 1'b0);

        // ---- abort during XFER of set 2
        rises0 = gd_rises;
        dones0 = done_pulses;
        do_start();
        fetch_set(0, 1, 2);
        fetch_set(1, 0, 3);
        wait_gd_high(2);
        check("abort_set_idx", 32'(which_data), 2);
        bus_busy = 1'b1;
        step(3);
        abort = 1'b1;
        step(1);
        abort    = 1'b0;
        bus_busy = 1'b0;
        check("abort_get_data", 32'(get_data), 0);
        check("abort_loaded", 32'(image_weights_loaded), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_seg_kept", 32'(seven_seg), 32'(model_seg));
        check("abort_error", 32'(error), 0);
        step(4);
        check("abort_no_done", 32'(done_pulses - dones0), 0);
        check("abort_req_count", 32'(gd_rises - rises0), 3);

        // ---- bus never acks: request must stay up for the whole budget
        do_start();
        cnt = 0;
        while (get_data === 1'b1 && cnt < 3 * TMO) begin
            cnt++;
            step(1);
        end
        check("tmo_req_cycles", 32'(cnt), TMO);
        check("tmo_error", 32'(error), 1);
        step(1);
        check("tmo_idle", 32'(busy), 0);
        check("tmo_error_sticky", 32'(error), 1);
        check("tmo_seg_kept", 32'(seven_seg), 32'(model_seg));
        do_start();
        check("restart_clears_error", 32'(error), 0);
        check("restart_get_data", 32'(get_data), 1);
        check("restart_which", 32'(which_data), 0);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("restart_abort_busy", 32'(busy), 0);

        // ---- ann_done on the same cycle the RUN budget runs out
        do_start();
        for (int k = 0; k < NUM_SETS; k++) fetch_set(k, 0, 1);
        check("race_start_det", 32'(start_detecting), 1);
        // RUN begins next cycle; its last in-budget cycle is TMO cycles later.
        step(TMO);
        ann_done      = 1'b1;
        ann_seven_seg = 8'hC3;
        step(1);
        ann_done  = 1'b0;
        model_seg = 8'hC3;
        check("race_done", 32'(done), 1);
        check("race_error", 32'(error), 0);
        check("race_seg", 32'(seven_seg), 32'(model_seg));
        step(2);

        // ---- start and abort together in IDLE are ignored
        rises0 = gd_rises;
        start = 1'b1;
        abort = 1'b1;
        step(1);
        start = 1'b0;
        abort = 1'b0;
        check("sa_get_data", 32'(get_data), 0);
        check("sa_busy", 32'(busy), 0);
        step(2);
        check("sa_req_count", 32'(gd_rises - rises0), 0);

        // ---- asynchronous reset while requesting set 2
        do_start();
        fetch_set(0, 0, 1);
        fetch_set(1, 1, 1);
        wait_gd_high(2);
        #2 rst = 1'b1;
        #1;
        check("arst_get_data", 32'(get_data), 0);
        check("arst_which_data", 32'(which_data), 0);
        check("arst_loaded", 32'(image_weights_loaded), 0);
        check("arst_start_det", 32'(start_detecting), 0);
        check("arst_seven_seg", 32'(seven_seg), 32'h0FF);
        check("arst_done", 32'(done), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_error", 32'(error), 0);
        @(negedge clk);
        rst = 1'b0;
        model_seg = 8'hFF;
        step(2);
        check("post_rst_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
